// File: rtl/cpu_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Shared forwarding-select codes, stage shadow record and long-op FSM states.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    localparam logic [5:0] REG_X0 = 6'd0;

    typedef struct packed {
        logic       valid;
        logic [5:0] rd;
        logic       we;
        logic       is_load;
    } stage_info_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } long_state_t;

endpackage

`default_nettype wire

// File: rtl/fwd_src_match.sv
// ============================================================================
// Module : fwd_src_match
// Resolves one ID source against the EX and MEM shadows; youngest producer wins.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_src_match
    import cpu_pkg::*;
(
    input  logic [5:0]  src,
    input  stage_info_t ex_info,
    input  stage_info_t mem_info,
    output logic [1:0]  sel
);

    logic w_ex_hit;
    logic w_mem_hit;
    logic unused_load;

    // x0 is hard-wired zero, but f0 (6'd32) is a real register and must match
    assign w_ex_hit  = ex_info.valid  && ex_info.we  && (ex_info.rd  == src) && (src != REG_X0);
    assign w_mem_hit = mem_info.valid && mem_info.we && (mem_info.rd == src) && (src != REG_X0);

    assign unused_load = ex_info.is_load ^ mem_info.is_load;

    always_comb begin
        sel = FWD_RF;
        if (w_ex_hit) begin
            sel = FWD_EXMEM;
        end else if (w_mem_hit) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fwd_hazard_ctrl.sv
// ============================================================================
// Module : fwd_hazard_ctrl
// Forwarding select, load-use stall and FDIV/FSQRT hold for the 5-stage pipe.
// Optional counters: define FWD_HAZARD_STATS_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int LONG_LAT = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic [5:0] id_rs1,
    input  logic [5:0] id_rs2,
    input  logic [5:0] id_rd,
    input  logic       id_we,
    input  logic       id_is_load,
    input  logic       id_is_long,
    output logic [1:0] fwd_a_sel,
    output logic [1:0] fwd_b_sel,
    output logic       stall_front,
    output logic       bubble_ex,
    output logic       hold_ex,
    output logic       long_busy
`ifdef FWD_HAZARD_STATS_EN
    ,
    output logic [31:0] stat_stall_cycles,
    output logic [31:0] stat_fwd_count
`endif
);

    // WB producers reach EX through the write-first register file, so only
    // EX and MEM need a shadow.
    stage_info_t r_ex;
    stage_info_t r_mem;
    stage_info_t w_id_info;

    logic [1:0]       r_sel_a;
    logic [1:0]       r_sel_b;
    logic [1:0]       w_match_a;
    logic [1:0]       w_match_b;
    logic [1:0]       w_sel_a;
    logic [1:0]       w_sel_b;
    logic             w_load_use;
    logic             w_long_issue;
    long_state_t      r_state;
    long_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign w_id_info = '{valid: id_valid, rd: id_rd, we: id_we, is_load: id_is_load};

    fwd_src_match u_match_a (
        .src      (id_rs1),
        .ex_info  (r_ex),
        .mem_info (r_mem),
        .sel      (w_match_a)
    );

    fwd_src_match u_match_b (
        .src      (id_rs2),
        .ex_info  (r_ex),
        .mem_info (r_mem),
        .sel      (w_match_b)
    );

    assign w_sel_a = id_valid ? w_match_a : FWD_RF;
    assign w_sel_b = id_valid ? w_match_b : FWD_RF;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        long_busy    = (r_state == ST_BUSY);
        hold_ex      = long_busy;
        w_load_use   = id_valid && r_ex.is_load &&
                       ((w_match_a == FWD_EXMEM) || (w_match_b == FWD_EXMEM));
        bubble_ex    = w_load_use && !long_busy;
        stall_front  = long_busy || w_load_use;
        w_long_issue = id_valid && id_is_long && !stall_front;

        case (r_state)
            ST_IDLE: begin
                if (w_long_issue) begin
                    w_state_nxt = ST_BUSY;
                    w_cnt_nxt   = CNT_W'(LONG_LAT - 1);
                end
            end
            ST_BUSY: begin
                // The op stays in EX one more (IDLE) cycle after the count ends
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex    <= '0;
            r_mem   <= '0;
            r_sel_a <= FWD_RF;
            r_sel_b <= FWD_RF;
        end else if (hold_ex) begin
            r_mem <= '0;
        end else begin
            r_mem   <= r_ex;
            r_ex    <= bubble_ex ? stage_info_t'('0) : w_id_info;
            r_sel_a <= bubble_ex ? FWD_RF : w_sel_a;
            r_sel_b <= bubble_ex ? FWD_RF : w_sel_b;
        end
    end

    assign fwd_a_sel = r_sel_a;
    assign fwd_b_sel = r_sel_b;

`ifdef FWD_HAZARD_STATS_EN
    logic [31:0] r_stat_stall;
    logic [31:0] r_stat_fwd;
    logic [32:0] w_stall_sum;
    logic [32:0] w_fwd_sum;
    logic [1:0]  w_fwd_inc;

    assign w_fwd_inc   = stall_front ? 2'd0 :
                         ({1'b0, (w_sel_a != FWD_RF)} + {1'b0, (w_sel_b != FWD_RF)});
    assign w_stall_sum = {1'b0, r_stat_stall} + {32'd0, stall_front};
    assign w_fwd_sum   = {1'b0, r_stat_fwd} + {31'd0, w_fwd_inc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_stall <= '0;
            r_stat_fwd   <= '0;
        end else begin
            r_stat_stall <= w_stall_sum[32] ? 32'hFFFF_FFFF : w_stall_sum[31:0];
            r_stat_fwd   <= w_fwd_sum[32]   ? 32'hFFFF_FFFF : w_fwd_sum[31:0];
        end
    end

    assign stat_stall_cycles = r_stat_stall;
    assign stat_fwd_count    = r_stat_fwd;
`endif

endmodule

`default_nettype wire
